// File: rtl/sort8_pkg.sv
// Shared constants and state encoding for the 8-entry frame sorter.
package sort8_pkg;
  localparam int N     = 8;
  localparam int IDX_W = 3;
  localparam int LEN_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t FILL = 2'd0;
  localparam state_t SORT = 2'd1;
  localparam state_t EMIT = 2'd2;

  localparam logic [7:0] PAD_DEFAULT = 8'hFF;
endpackage

// File: rtl/sort8_asc_net.sv
// Combinational 8-input ascending sorter (odd-even transposition, N stages).
module sort8_asc_net
  import sort8_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [N-1:0][W-1:0] din,
  output logic [N-1:0][W-1:0] dout
);
  genvar gs, gi;

  // Even stages swap pairs (0,1),(2,3)..; odd stages swap (1,2),(3,4)..
  for (gs = 0; gs < N; gs++) begin : g_stg
    logic [N-1:0][W-1:0] a;
    logic [N-1:0][W-1:0] v;

    if (gs == 0) begin : g_first
      assign a = din;
    end else begin : g_next
      assign a = g_stg[gs-1].v;
    end

    for (gi = 0; gi < N; gi++) begin : g_cell
      if (((gi % 2) == (gs % 2)) && (gi < N - 1)) begin : g_lo
        assign v[gi] = (a[gi+1] < a[gi]) ? a[gi+1] : a[gi];
      end else if (((gi % 2) != (gs % 2)) && (gi > 0)) begin : g_hi
        assign v[gi] = (a[gi-1] < a[gi]) ? a[gi] : a[gi-1];
      end else begin : g_pass
        assign v[gi] = a[gi];
      end
    end
  end

  assign dout = g_stg[N-1].v;
endmodule

// File: rtl/sort8_frame_ctrl.sv
// Collects up to 8 words, sorts them in one cycle, and replays them ascending.
module sort8_frame_ctrl
  import sort8_pkg::*;
#(
  parameter int         W   = 8,
  parameter logic [W-1:0] PAD = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy
);
  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [N-1:0][W-1:0]  buf_q, buf_d;
  logic [N-1:0][W-1:0]  sorted_q, sorted_d;
  logic [N-1:0][W-1:0]  net_out;

  sort8_asc_net #(.W(W)) u_net (
    .din  (buf_q),
    .dout (net_out)
  );

  // in_ready is forced low during reset so no beat is acknowledged while flops are held.
  assign in_ready  = (state_q == FILL) && !rst;
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_valid ? sorted_q[idx_q] : '0;
  assign out_last  = out_valid && ((LEN_W'(idx_q) + LEN_W'(1)) == len_q);
  assign busy      = (state_q != FILL);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    len_d    = len_q;
    buf_d    = buf_q;
    sorted_d = sorted_q;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          buf_d[cnt_q] = in_data;
          cnt_d        = cnt_q + 3'd1;
          if ((cnt_q == 3'd7) || in_last) begin
            len_d   = LEN_W'(cnt_q) + LEN_W'(1);
            state_d = SORT;
          end
        end
      end
      SORT: begin
        sorted_d = net_out;
        state_d  = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          idx_d = idx_q + 3'd1;
          if (out_last) begin
            idx_d   = '0;
            cnt_d   = '0;
            buf_d   = {N{PAD}};
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      buf_q    <= {N{PAD}};
      sorted_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      buf_q    <= buf_d;
      sorted_q <= sorted_d;
    end
  end
endmodule
